// File: rtl/proc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | proc_pkg                                                           |
// | Shared sequencer state encoding and instruction phase constants.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int NUM_PHASES_DEFAULT = 5;

  localparam logic [2:0] PH_FETCH  = 3'd0;
  localparam logic [2:0] PH_DECODE = 3'd1;
  localparam logic [2:0] PH_EXEC   = 3'd2;
  localparam logic [2:0] PH_MEM    = 3'd3;
  localparam logic [2:0] PH_WB     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_edge_detect                                                   |
// | Multi-flop synchroniser for an asynchronous level, followed by a   |
// | one-cycle rising-edge pulse.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  // Fewer than two stages gives no metastability protection, so clamp.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      edge_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_o = sync_q[STAGES-1] & ~edge_q;

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | phase_sequencer                                                    |
// | Instruction phase counter with run/step/halt control, one-hot      |
// | phase enables and a saturating completed-instruction counter.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module phase_sequencer
  import proc_pkg::*;
#(
  parameter int NUM_PHASES  = NUM_PHASES_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step_mode,
  input  logic                  halt,
  output logic [2:0]            phase,
  output logic [NUM_PHASES-1:0] p_en,
  output logic                  running,
  output logic                  halted,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

  state_e             state_q, state_d;
  logic [2:0]         phase_q, phase_d;
  logic               stop_req_q, stop_req_d;
  logic               halt_req_q, halt_req_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               exec_pulse;
  logic               stop_eff;
  logic               halt_eff;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_exec_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (exec),
    .pulse_o (exec_pulse)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      stop_req_q <= 1'b0;
      halt_req_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      stop_req_q <= stop_req_d;
      halt_req_q <= halt_req_d;
      count_q    <= count_d;
    end
  end

  // Requests raised in the boundary cycle itself still count at that boundary.
  assign stop_eff = stop_req_q | exec_pulse;
  assign halt_eff = halt_req_q | halt;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    stop_req_d = stop_req_q;
    halt_req_d = halt_req_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        phase_d    = PH_FETCH;
        stop_req_d = 1'b0;
        halt_req_d = 1'b0;
        if (exec_pulse) begin
          state_d    = step_mode ? ST_STEP : ST_RUN;
          halt_req_d = halt;
        end
      end

      ST_RUN, ST_STEP: begin
        stop_req_d = stop_eff;
        halt_req_d = halt_eff;
        if (phase_q > LAST_PHASE) begin
          phase_d = PH_FETCH;
        end else if (phase_q == LAST_PHASE) begin
          phase_d    = PH_FETCH;
          stop_req_d = 1'b0;
          halt_req_d = 1'b0;
          if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
          end
          if (halt_eff) begin
            state_d = ST_HALTED;
          end else if (stop_eff || (state_q == ST_STEP)) begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end

      ST_HALTED: begin
        phase_d    = PH_FETCH;
        stop_req_d = 1'b0;
        halt_req_d = 1'b0;
        if (exec_pulse) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        phase_d    = PH_FETCH;
        stop_req_d = 1'b0;
        halt_req_d = 1'b0;
      end
    endcase
  end

  assign phase       = phase_q;
  assign running     = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign halted      = (state_q == ST_HALTED);
  assign instr_count = count_q;
  assign p_en        = running ? (NUM_PHASES'(1) << phase_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_phase_sequencer                                                 |
// | Scoreboard bench: a cycle-level reference model queues expected    |
// | outputs at each edge; a monitor compares them shortly after.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_phase_sequencer;

  localparam int NP = 5;
  localparam int SS = 2;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          exec;
  logic          step_mode;
  logic          halt;
  logic [2:0]    phase;
  logic [NP-1:0] p_en;
  logic          running;
  logic          halted;
  logic [CW-1:0] instr_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int phase;
    int p_en;
    bit running;
    bit halted;
    int count;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  phase_sequencer #(
    .NUM_PHASES  (NP),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .exec        (exec),
    .step_mode   (step_mode),
    .halt        (halt),
    .phase       (phase),
    .p_en        (p_en),
    .running     (running),
    .halted      (halted),
    .instr_count (instr_count)
  );

  // Reference model: an instruction is "active" for NP cycles; flags describe
  // what happens when it completes.
  bit m_active, m_single, m_halted, m_stop, m_halt;
  int m_phase, m_count;
  bit hist[$];

  task automatic model_reset();
    m_active = 0; m_single = 0; m_halted = 0; m_stop = 0; m_halt = 0;
    m_phase = 0; m_count = 0;
    hist.delete();
    for (int i = 0; i <= SS; i++) hist.push_back(1'b0);
  endtask

  always @(posedge clock) begin
    bit   pulse;
    exp_t e;
    if (reset) begin
      model_reset();
    end else begin
      // hist[i] holds exec as sampled i+1 edges ago
      pulse = hist[SS-1] && !hist[SS];
      hist.push_front(exec);
      void'(hist.pop_back());
      if (m_halted) begin
        if (pulse) m_halted = 0;
      end else if (!m_active) begin
        if (pulse) begin
          m_active = 1;
          m_single = step_mode;
          m_halt   = halt;
          m_stop   = 0;
          m_phase  = 0;
        end
      end else begin
        if (pulse) m_stop = 1;
        if (halt)  m_halt = 1;
        if (m_phase == NP - 1) begin
          m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
          m_phase = 0;
          if (m_halt) begin
            m_active = 0;
            m_halted = 1;
          end else if (m_stop || m_single) begin
            m_active = 0;
          end
          m_stop = 0;
          m_halt = 0;
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
    e.phase   = m_phase;
    e.running = m_active;
    e.halted  = m_halted;
    e.p_en    = m_active ? (1 << m_phase) : 0;
    e.count   = m_count;
    exp_q.push_back(e);
  end

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (int'(phase) != e.phase || int'(p_en) != e.p_en || running != e.running ||
          halted != e.halted || int'(instr_count) != e.count) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got ph=%0d pen=%b run=%0b hlt=%0b cnt=%0d expected ph=%0d pen=%b run=%0b hlt=%0b cnt=%0d",
                 $time, phase, p_en, running, halted, instr_count,
                 e.phase, e.p_en[NP-1:0], e.running, e.halted, e.count);
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_exec(input int hold);
    exec = 1'b1;
    tick(hold);
    exec = 1'b0;
  endtask

  initial begin
    reset = 1'b1; exec = 1'b0; step_mode = 1'b0; halt = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Free run, then stop request
    pulse_exec(1);
    tick(SS + 18);
    pulse_exec(1);
    tick(15);

    // Single step, then exec held high
    step_mode = 1'b1;
    pulse_exec(1);
    tick(12);
    pulse_exec(20);
    tick(10);
    step_mode = 1'b0;

    // Halt mid-instruction, release, restart
    pulse_exec(1);
    tick(SS + 1);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    tick(10);
    pulse_exec(1);
    tick(6);
    pulse_exec(1);
    tick(7);

    // exec pulse and halt landing together while running
    exec = 1'b1;
    tick(SS);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    exec = 1'b0;
    tick(12);
    pulse_exec(1);
    tick(6);

    // Asynchronous reset mid-instruction with an exec pulse in flight
    pulse_exec(1);
    tick(SS + 4);
    pulse_exec(1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_phase",   int'(phase), 0);
    chk("async_rst_p_en",    int'(p_en), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_halted",  int'(halted), 0);
    chk("async_rst_count",   int'(instr_count), 0);
    tick(2);
    reset = 1'b0;
    tick(8);
    chk("rst_discards_exec", int'(running), 0);

    // Counter saturation over 20 instructions
    pulse_exec(1);
    tick(SS + 20 * NP);
    chk("count_saturated", int'(instr_count), CNT_MAX);
    pulse_exec(1);
    tick(12);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) exec = ~exec;
      halt = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) step_mode = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1499) == 0) reset = 1'b1;
      else reset = 1'b0;
      tick(1);
    end
    reset = 1'b0; exec = 1'b0; halt = 1'b0;
    tick(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
